uart_rx: RTL and testbench

Serial-to-parallel UART receiver for 8N1 frames at a fixed 434-clock bit period; the receive-side counterpart of the team's UART transmitter. It samples the asynchronous `uart_in` pin and delivers each correctly framed byte with a one-cycle valid strobe. Framing errors are flagged separately. It sits between the board RX pin and the command decoder.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, bit-period terminal counts, data width.
package uart_pkg;

    localparam logic [8:0] P_BIT_CNT  = 9'd433;
    localparam logic [8:0] P_HALF_CNT = 9'd216;
    localparam int         DATA_W     = 8;

    typedef enum logic [4:0] {
        P_IDLE      = 5'b00001,
        P_START_BIT = 5'b00010,
        P_DATA_BITS = 5'b00100,
        P_STOP_BIT  = 5'b01000,
        P_WAIT_HIGH = 5'b10000
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 (idle-high line).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 434 clocks per bit. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic              uart_dec_valid_in,
    output logic [DATA_W-1:0] uart_dec_data_in,
    output logic              uart_dec_frame_err
);

    uart_state_e       state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              line;
    logic              bit_s;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (uart_in),
        .sync_o  (line)
    );

`ifdef UART_RX_MAJORITY_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // hist_q[1] is the line two cycles ago, hist_q[0] one cycle ago
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= {hist_q[0], line};
    end

    assign bit_s = maj3(hist_q[1], hist_q[0], line);
`else
    assign bit_s = line;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 9'd1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            P_IDLE: begin
                cnt_d = '0;
                if (!line) state_d = P_START_BIT;
            end
            P_START_BIT: begin
                if (cnt_q == P_HALF_CNT) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = bit_s ? P_IDLE : P_DATA_BITS;
                end
            end
            P_DATA_BITS: begin
                if (cnt_q == P_BIT_CNT) begin
                    cnt_d   = '0;
                    shreg_d = {bit_s, shreg_q[DATA_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = P_STOP_BIT;
                end
            end
            P_STOP_BIT: begin
                if (cnt_q == P_BIT_CNT) begin
                    cnt_d = '0;
                    if (bit_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = P_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = P_WAIT_HIGH;
                    end
                end
            end
            P_WAIT_HIGH: begin
                cnt_d = '0;
                if (line) state_d = P_IDLE;
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = P_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= P_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign uart_dec_valid_in  = valid_q;
    assign uart_dec_data_in   = data_q;
    assign uart_dec_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed frames against a frame-level event model of the UART receiver.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT = 434;
    // pin falling edge driven after edge k -> strobe visible after edge k+LAT
    localparam int LAT = 4126;

`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_in = 1'b1;
    logic       valid;
    logic       ferr;
    logic [7:0] data;

    uart_rx dut (
        .clk                (clk),
        .rst                (rst),
        .uart_in            (uart_in),
        .uart_dec_valid_in  (valid),
        .uart_dec_data_in   (data),
        .uart_dec_frame_err (ferr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         at;
        bit         is_err;
        logic [7:0] b;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    bit         cmp_en = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         n_valid = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        bit ev_v;
        bit ev_e;
        ev_v = 1'b0;
        ev_e = 1'b0;
        if (cmp_en) begin
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                if (exp_q[0].is_err) ev_e = 1'b1;
                else begin
                    ev_v = 1'b1;
                    model_data = exp_q[0].b;
                end
                void'(exp_q.pop_front());
            end
            if (valid === 1'b1) n_valid++;
            if (ferr === 1'b1) n_err++;
            chk("valid", {31'd0, valid}, {31'd0, ev_v});
            chk("frame_err", {31'd0, ferr}, {31'd0, ev_e});
            chk("data", {24'd0, data}, {24'd0, model_data});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            uart_in = 1'b1;
        end
    endtask

    // cut>0 truncates the frame after cut cycles and expects no strobe
    task automatic send(input logic [7:0] b, input int nstop, input bit stop_low,
                        input int low_hold, input bit glitch, input int cut);
        int  len;
        ev_t e;
        len = stop_low ? (10 * BIT + low_hold) : ((9 + nstop) * BIT);
        if (cut > 0) len = cut;
        for (int off = 0; off < len; off++) begin
            logic v;
            @(posedge clk); #1;
            if (off == 0 && cut == 0) begin
                e.at     = cyc + LAT;
                e.is_err = stop_low;
                e.b      = (glitch && !MAJ) ? ~b : b;
                exp_q.push_back(e);
            end
            if (off < BIT) v = 1'b0;
            else if (off < 9 * BIT) begin
                v = b[(off - BIT) / BIT];
                if (glitch && ((off - BIT) % BIT) == 217) v = ~v;
            end else v = stop_low ? 1'b0 : 1'b1;
            uart_in = v;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        uart_in = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        model_data = 8'h00;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_ferr", {31'd0, ferr}, 32'd0);
        chk("reset_data", {24'd0, data}, 32'h00);
        idle(10);

        // single frame, two stop bits
        send(8'hA5, 2, 1'b0, 0, 1'b0, 0);
        chk("a5_data", {24'd0, data}, 32'hA5);
        chk("a5_nvalid", n_valid, 1);
        chk("a5_nerr", n_err, 0);

        // 100-cycle low glitch, then a frame shortly after the FSM returns to idle
        send(8'h00, 1, 1'b0, 0, 1'b0, 100);
        idle(125);
        send(8'h3C, 2, 1'b0, 0, 1'b0, 0);
        chk("glitch_data", {24'd0, data}, 32'h3C);
        chk("glitch_nvalid", n_valid, 2);

        // stop bit low, line held low, then recovery
        send(8'hE7, 1, 1'b1, 2000, 1'b0, 0);
        chk("ferr_data_kept", {24'd0, data}, 32'h3C);
        chk("ferr_nerr", n_err, 1);
        chk("ferr_nvalid", n_valid, 2);
        idle(10);
        send(8'h5A, 2, 1'b0, 0, 1'b0, 0);
        chk("after_ferr_data", {24'd0, data}, 32'h5A);

        // back-to-back, two then one stop bit
        send(8'h00, 2, 1'b0, 0, 1'b0, 0);
        send(8'hFF, 2, 1'b0, 0, 1'b0, 0);
        send(8'h81, 2, 1'b0, 0, 1'b0, 0);
        chk("b2b2_data", {24'd0, data}, 32'h81);
        send(8'h00, 1, 1'b0, 0, 1'b0, 0);
        send(8'hFF, 1, 1'b0, 0, 1'b0, 0);
        send(8'h81, 1, 1'b0, 0, 1'b0, 0);
        chk("b2b1_data", {24'd0, data}, 32'h81);
        chk("b2b_nvalid", n_valid, 9);
        chk("b2b_nerr", n_err, 1);

        // reset during data bit 3 aborts the frame
        send(8'h96, 1, 1'b0, 0, 1'b0, 1900);
        pulse_reset();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ferr", {31'd0, ferr}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'h00);
        idle(20);
        send(8'hC3, 2, 1'b0, 0, 1'b0, 0);
        chk("after_rst_data", {24'd0, data}, 32'hC3);
        chk("after_rst_nvalid", n_valid, 10);

        // one-cycle inverted glitch at every data sample point
        send(8'h55, 2, 1'b0, 0, 1'b1, 0);
        chk("sample_glitch_data", {24'd0, data}, MAJ ? 32'h55 : 32'hAA);

        // randomized frames with random stop-bit count and idle gaps
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom_range(0, 255)), $urandom_range(1, 2), 1'b0, 0, 1'b0, 0);
            idle($urandom_range(0, 40));
        end

        idle(20);
        chk("pending_events", exp_q.size(), 0);
        chk("total_nvalid", n_valid, 14);
        chk("total_nerr", n_err, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
